// File: rtl/av_burst_master_pkg.sv
// av_burst_master_pkg: shared Avalon burst-master FSM states and response codes.
package av_burst_master_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_BURST,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_DONE
    } state_t;
    localparam logic [1:0] AV_RESP_OKAY = 2'b00;
endpackage

// File: rtl/av_burst_master.sv
// av_burst_master: one command in, one Avalon-MM burst out; write beats from a
// valid/ready stream, read beats returned as a valid-only stream.
module av_burst_master
    import av_burst_master_pkg::*;
#(
    parameter int dw     = 32,
    parameter int aw     = 32,
    parameter int burstw = 8
) (
    input  logic              av_clk_i,
    input  logic              av_rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_write_i,
    input  logic [aw-1:0]     cmd_address_i,
    input  logic [burstw-1:0] cmd_burstcount_i,
    input  logic [dw-1:0]     wr_data_i,
    input  logic [dw/8-1:0]   wr_be_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    output logic [dw-1:0]     rd_data_o,
    output logic              rd_valid_o,
    output logic              done_o,
    output logic              err_o,
    output logic [aw-1:0]     av_address_o,
    output logic [burstw-1:0] av_burstcount_o,
    output logic [dw-1:0]     av_writedata_o,
    output logic [dw/8-1:0]   av_byteenable_o,
    output logic              av_write_o,
    output logic              av_read_o,
    input  logic              av_waitrequest_i,
    input  logic              av_readdatavalid_i,
    input  logic [1:0]        av_response_i,
    input  logic [dw-1:0]     av_readdata_i
);
    localparam logic [aw-1:0] ADDR_MASK = ~aw'(dw/8 - 1);

    state_t            r_state, w_next;
    logic [aw-1:0]     r_addr;
    logic [burstw-1:0] r_count, r_beat_cnt;
    logic              r_err, r_rd_valid;
    logic [dw-1:0]     r_rd_data;
    logic              w_accept, w_wr_beat, w_rd_beat, w_last, w_stray;

    assign w_accept  = (r_state == ST_IDLE) & cmd_valid_i;
    assign w_wr_beat = (r_state == ST_WR_BURST) & wr_valid_i & ~av_waitrequest_i;
    assign w_rd_beat = (r_state == ST_RD_DATA) & av_readdatavalid_i;
    assign w_stray   = (r_state != ST_RD_DATA) & av_readdatavalid_i;
    assign w_last    = r_beat_cnt == burstw'(1);

    always_ff @(posedge av_clk_i or posedge av_rst_i)
        if (av_rst_i) r_state <= ST_IDLE;
        else          r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (cmd_valid_i)
                             w_next = (cmd_burstcount_i == '0) ? ST_DONE :
                                      cmd_write_i ? ST_WR_BURST : ST_RD_REQ;
            ST_WR_BURST: if (w_wr_beat && w_last) w_next = ST_DONE;
            ST_RD_REQ:   if (!av_waitrequest_i) w_next = ST_RD_DATA;
            ST_RD_DATA:  if (w_rd_beat && w_last) w_next = ST_DONE;
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o     = r_state == ST_IDLE;
        av_write_o      = (r_state == ST_WR_BURST) & wr_valid_i;
        wr_ready_o      = (r_state == ST_WR_BURST) & wr_valid_i & ~av_waitrequest_i;
        av_read_o       = r_state == ST_RD_REQ;
        done_o          = r_state == ST_DONE;
        av_writedata_o  = (r_state == ST_WR_BURST) ? wr_data_i : '0;
        av_byteenable_o = (r_state == ST_WR_BURST) ? wr_be_i :
                          (r_state == ST_RD_REQ) ? '1 : '0;
    end

    // Stray read beats and errored responses both land in the sticky error;
    // the set is ordered after the accept-clear so a same-cycle stray wins.
    always_ff @(posedge av_clk_i or posedge av_rst_i)
        if (av_rst_i) begin
            r_addr     <= '0;
            r_count    <= '0;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= w_rd_beat;
            if (w_rd_beat) r_rd_data <= av_readdata_i;
            if (w_accept) begin
                r_addr     <= cmd_address_i & ADDR_MASK;
                r_count    <= cmd_burstcount_i;
                r_beat_cnt <= cmd_burstcount_i;
            end else if ((w_wr_beat || w_rd_beat) && r_beat_cnt != '0)
                r_beat_cnt <= r_beat_cnt - burstw'(1);
            if (w_accept) r_err <= cmd_burstcount_i == '0;
            if ((w_rd_beat && av_response_i != AV_RESP_OKAY) || w_stray) r_err <= 1'b1;
        end

    assign av_address_o    = r_addr;
    assign av_burstcount_o = r_count;
    assign err_o           = r_err;
    assign rd_valid_o      = r_rd_valid;
    assign rd_data_o       = r_rd_data;
endmodule

// File: tb/tb_av_burst_master.sv
// tb_av_burst_master: directed bench driving av_burst_master into a 32KB
// behavioural Avalon memory with random read-return gaps.
module tb_av_burst_master;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_address;
    logic [7:0]  cmd_burstcount;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;
    logic        wr_valid, wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid, done, err;
    logic [31:0] av_address, av_writedata, av_readdata;
    logic [7:0]  av_burstcount;
    logic [3:0]  av_byteenable;
    logic        av_write, av_read, av_waitrequest, av_readdatavalid;
    logic [1:0]  av_response;
    logic        stall, inj_rdv, mem_rdv;
    logic [31:0] mem_rdata, rd_ptr;
    logic [1:0]  mem_resp;
    logic [31:0] mem [0:8191];
    int          rd_pend, rd_dly, wr_idx;
    int          wr_xfers = 0, rd_reqs = 0, done_cnt = 0;
    logic [31:0] rd_got [$];
    int          compared = 0, mismatched = 0;

    always #5 clk = ~clk;

    av_burst_master dut (
        .av_clk_i(clk), .av_rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_address_i(cmd_address), .cmd_burstcount_i(cmd_burstcount),
        .wr_data_i(wr_data), .wr_be_i(wr_be), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .done_o(done), .err_o(err),
        .av_address_o(av_address), .av_burstcount_o(av_burstcount),
        .av_writedata_o(av_writedata), .av_byteenable_o(av_byteenable),
        .av_write_o(av_write), .av_read_o(av_read),
        .av_waitrequest_i(av_waitrequest), .av_readdatavalid_i(av_readdatavalid),
        .av_response_i(av_response), .av_readdata_i(av_readdata)
    );

    assign av_waitrequest   = stall;
    assign av_readdatavalid = mem_rdv | inj_rdv;
    assign av_readdata      = mem_rdata;
    assign av_response      = mem_resp;

    // Memory model: addresses >= 32KB answer with SLVERR and a marker word.
    always @(posedge clk) begin
        if (rst) begin
            rd_pend   <= 0;
            rd_dly    <= 0;
            wr_idx    <= 0;
            mem_rdv   <= 1'b0;
            mem_rdata <= '0;
            mem_resp  <= 2'b00;
        end else begin
            mem_rdv <= 1'b0;
            if (rd_pend > 0) begin
                if (rd_dly > 0) rd_dly <= rd_dly - 1;
                else begin
                    mem_rdv   <= 1'b1;
                    mem_rdata <= (rd_ptr < 32'h8000) ? mem[rd_ptr[14:2]] : 32'hDEAD_BEEF;
                    mem_resp  <= (rd_ptr < 32'h8000) ? 2'b00 : 2'b10;
                    rd_ptr    <= rd_ptr + 32'd4;
                    rd_pend   <= rd_pend - 1;
                    rd_dly    <= $urandom_range(0, 4);
                end
            end
            if (av_read && !av_waitrequest) begin
                rd_pend <= int'(av_burstcount);
                rd_ptr  <= av_address;
                rd_dly  <= $urandom_range(0, 4);
            end
            if (av_write && !av_waitrequest) begin
                mem[int'(av_address[14:2]) + wr_idx] <= av_writedata;
                wr_idx <= wr_idx + 1;
            end
            if (done) wr_idx <= 0;
        end
    end

    always @(posedge clk)
        if (!rst) begin
            if (av_write && !av_waitrequest) wr_xfers <= wr_xfers + 1;
            if (av_read) rd_reqs <= rd_reqs + 1;
            if (done) done_cnt <= done_cnt + 1;
            if (rd_valid) rd_got.push_back(rd_data);
        end

    task automatic do_cmd(input logic w, input logic [31:0] a, input logic [7:0] n);
        int t = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_address = a; cmd_burstcount = n;
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        compared++;
        if (cmd_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1 (addr %h)", cmd_ready, a);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int t = 0;
        while (done_cnt == d0 && t < 200) begin @(negedge clk); t++; end
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (done_cnt != d0 + 1) begin
            mismatched++;
            $display("FAIL %s done_count: got %0d required 1", name, done_cnt - d0);
        end
    endtask

    task automatic feed(input int n, input logic [31:0] base, input bit gap,
                        input logic [31:0] ea, input logic [7:0] ec);
        int idx = 0, cyc = 0;
        while (idx < n && cyc < 100) begin
            wr_valid = gap ? (cyc % 2 == 0) : 1'b1;
            wr_data  = base + 32'(idx);
            wr_be    = 4'hF;
            #1;
            compared++;
            if (av_address !== ea || av_burstcount !== ec || av_write !== wr_valid) begin
                mismatched++;
                $display("FAIL wr_bus cyc%0d: addr=%h cnt=%0d write=%b required %h %0d %b",
                         cyc, av_address, av_burstcount, av_write, ea, ec, wr_valid);
            end
            if (wr_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        wr_valid = 1'b0;
        compared++;
        if (idx != n) begin
            mismatched++;
            $display("FAIL wr_feed beats: got %0d required %0d", idx, n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_address = 0; cmd_burstcount = 0;
        wr_data = 0; wr_be = 0; wr_valid = 0; stall = 0; inj_rdv = 0;
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        compared++;
        if ({av_write, av_read, done, err, rd_valid, wr_ready, cmd_ready} !== 7'b0000001 ||
            av_address !== '0 || av_burstcount !== '0) begin
            mismatched++;
            $display("FAIL reset_state: wr=%b rd=%b done=%b err=%b rdv=%b wrdy=%b crdy=%b addr=%h",
                     av_write, av_read, done, err, rd_valid, wr_ready, cmd_ready, av_address);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write;
        int d0 = done_cnt, w0 = wr_xfers;
        do_cmd(1'b1, 32'h100, 8'd4);
        feed(4, 32'hA0, 1'b0, 32'h100, 8'd4);
        wait_done(d0, "write");
        compared++;
        if (wr_xfers - w0 != 4 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL write_beats: beats=%0d err=%b required 4 0", wr_xfers - w0, err);
        end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (mem[32'h40 + i] !== 32'hA0 + 32'(i)) begin
                mismatched++;
                $display("FAIL write_mem[%0d]: got %h required %h", i, mem[32'h40 + i], 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_read(input logic [31:0] a, input int n, input int stall_n,
                             input logic [31:0] base, input logic bad);
        int d0 = done_cnt, r0 = rd_reqs;
        logic [31:0] e;
        rd_got.delete();
        stall = stall_n > 0;
        do_cmd(1'b0, a, 8'(n));
        compared++;
        if (err !== 1'b0 || av_address !== (a & ~32'd3) || av_burstcount !== 8'(n)) begin
            mismatched++;
            $display("FAIL read_cmd: err=%b addr=%h cnt=%0d required 0 %h %0d",
                     err, av_address, av_burstcount, a & ~32'd3, n);
        end
        for (int i = 0; i < stall_n; i++) begin
            compared++;
            if (av_read !== 1'b1 || av_address !== (a & ~32'd3)) begin
                mismatched++;
                $display("FAIL read_hold cyc%0d: read=%b addr=%h required 1 %h", i, av_read, av_address, a & ~32'd3);
            end
            @(negedge clk);
        end
        stall = 1'b0;
        wait_done(d0, "read");
        compared++;
        if (rd_reqs - r0 != stall_n + 1 || rd_got.size() != n || err !== bad) begin
            mismatched++;
            $display("FAIL read_summary: req_cycles=%0d beats=%0d err=%b required %0d %0d %b",
                     rd_reqs - r0, rd_got.size(), err, stall_n + 1, n, bad);
        end
        for (int i = 0; i < n && i < rd_got.size(); i++) begin
            e = bad ? 32'hDEAD_BEEF : base + 32'(i);
            compared++;
            if (rd_got[i] !== e) begin
                mismatched++;
                $display("FAIL read_data[%0d]: got %h required %h", i, rd_got[i], e);
            end
        end
    endtask

    task automatic test_gap;
        int d0 = done_cnt, w0 = wr_xfers;
        do_cmd(1'b1, 32'h200, 8'd3);
        feed(3, 32'hC0, 1'b1, 32'h200, 8'd3);
        wait_done(d0, "gap");
        compared++;
        if (wr_xfers - w0 != 3 || mem[32'h80] !== 32'hC0 || mem[32'h81] !== 32'hC1 || mem[32'h82] !== 32'hC2) begin
            mismatched++;
            $display("FAIL gap_write: beats=%0d mem=%h %h %h required 3 c0 c1 c2",
                     wr_xfers - w0, mem[32'h80], mem[32'h81], mem[32'h82]);
        end
    endtask

    task automatic test_zero_count;
        int d0 = done_cnt, w0 = wr_xfers, r0 = rd_reqs;
        do_cmd(1'b1, 32'h300, 8'd0);
        compared++;
        if (done !== 1'b1 || err !== 1'b1 || av_write !== 1'b0 || av_read !== 1'b0) begin
            mismatched++;
            $display("FAIL zero_done: done=%b err=%b wr=%b rd=%b required 1 1 0 0", done, err, av_write, av_read);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || err !== 1'b1) begin
            mismatched++;
            $display("FAIL zero_after: done=%b ready=%b err=%b required 0 1 1", done, cmd_ready, err);
        end
        compared++;
        if (wr_xfers != w0 || rd_reqs != r0 || done_cnt != d0 + 1) begin
            mismatched++;
            $display("FAIL zero_bus: wr=%0d rd=%0d done=%0d required 0 0 1", wr_xfers - w0, rd_reqs - r0, done_cnt - d0);
        end
        test_read(32'h100, 1, 0, 32'hA0, 1'b0);
    endtask

    task automatic test_stray;
        int s0 = rd_got.size();
        inj_rdv = 1'b1;
        @(negedge clk);
        inj_rdv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        compared++;
        if (err !== 1'b1 || rd_got.size() != s0) begin
            mismatched++;
            $display("FAIL stray_beat: err=%b forwarded=%0d required 1 0", err, rd_got.size() - s0);
        end
    endtask

    task automatic test_back_to_back;
        int d0 = done_cnt;
        do_cmd(1'b1, 32'h500, 8'd1);
        feed(1, 32'hE0, 1'b0, 32'h500, 8'd1);
        compared++;
        if (done !== 1'b1 || cmd_ready !== 1'b0 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL b2b_done: done=%b ready=%b err=%b required 1 0 0", done, cmd_ready, err);
        end
        @(negedge clk);
        compared++;
        if (cmd_ready !== 1'b1 || done_cnt != d0 + 1) begin
            mismatched++;
            $display("FAIL b2b_ready: ready=%b dones=%0d required 1 1", cmd_ready, done_cnt - d0);
        end
        test_read(32'h503, 1, 0, 32'hE0, 1'b0);
    endtask

    task automatic test_reset_mid;
        int d0 = done_cnt;
        do_cmd(1'b1, 32'h400, 8'd4);
        wr_valid = 1'b1; wr_be = 4'hF; wr_data = 32'hB0;
        @(negedge clk);
        wr_data = 32'hB1;
        #1;
        rst = 1'b1;
        #1;
        compared++;
        if (av_write !== 1'b0 || wr_ready !== 1'b0 || av_address !== '0 || av_burstcount !== '0) begin
            mismatched++;
            $display("FAIL mid_reset: write=%b ready=%b addr=%h cnt=%0d required 0 0 0 0",
                     av_write, wr_ready, av_address, av_burstcount);
        end
        @(negedge clk);
        @(negedge clk);
        wr_valid = 1'b0;
        rst = 1'b0;
        #1;
        compared++;
        if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || done_cnt != d0) begin
            mismatched++;
            $display("FAIL post_reset: ready=%b done=%b err=%b dones=%0d required 1 0 0 0",
                     cmd_ready, done, err, done_cnt - d0);
        end
        @(negedge clk);
        d0 = done_cnt;
        do_cmd(1'b1, 32'h400, 8'd2);
        feed(2, 32'hD0, 1'b0, 32'h400, 8'd2);
        wait_done(d0, "fresh");
        compared++;
        if (mem[32'h100] !== 32'hD0 || mem[32'h101] !== 32'hD1 || mem[32'h102] !== 32'h0) begin
            mismatched++;
            $display("FAIL fresh_write: mem=%h %h %h required d0 d1 0", mem[32'h100], mem[32'h101], mem[32'h102]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read(32'h100, 4, 2, 32'hA0, 1'b0);
        test_gap();
        test_zero_count();
        test_read(32'h0010_0000, 3, 0, 32'h0, 1'b1);
        test_stray();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
